// File: rtl/pclk_mode_pkg.sv
// Mode encodings, sequencer states and per-mode DCM/timing table for the HDMI TX pixel-clock chain.
package pclk_mode_pkg;

  localparam logic [1:0] MODE_1080P = 2'd0;
  localparam logic [1:0] MODE_720P  = 2'd1;
  localparam logic [1:0] MODE_480P  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_PROG,
    ST_WAIT_DONE,
    ST_WAIT_DCM,
    ST_WAIT_PLL,
    ST_SETTLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  typedef struct packed {
    logic [7:0]  m;
    logic [7:0]  d;
    logic [11:0] hsblnk;
    logic [11:0] hssync;
    logic [11:0] hesync;
    logic [11:0] heblnk;
    logic [11:0] vsblnk;
    logic [11:0] vssync;
    logic [11:0] vesync;
    logic [11:0] veblnk;
    logic        pol;
  } mode_cfg_t;

  // M and D are stored already minus one, as the dcmspi expects them.
  function automatic mode_cfg_t mode_cfg(input logic [1:0] mode);
    mode_cfg_t c;
    case (mode)
      MODE_720P: c = '{m: 8'd198, d: 8'd133,
                       hsblnk: 12'd1279, hssync: 12'd1389, hesync: 12'd1429, heblnk: 12'd1649,
                       vsblnk: 12'd719,  vssync: 12'd724,  vesync: 12'd729,  veblnk: 12'd749,
                       pol: 1'b0};
      MODE_480P: c = '{m: 8'd26, d: 8'd49,
                       hsblnk: 12'd719, hssync: 12'd735, hesync: 12'd797, heblnk: 12'd857,
                       vsblnk: 12'd479, vssync: 12'd488, vesync: 12'd494, veblnk: 12'd524,
                       pol: 1'b1};
      default:   c = '{m: 8'd198, d: 8'd66,
                       hsblnk: 12'd1919, hssync: 12'd2007, hesync: 12'd2051, heblnk: 12'd2199,
                       vsblnk: 12'd1079, vssync: 12'd1083, vesync: 12'd1088, veblnk: 12'd1124,
                       pol: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pclk_mode_sequencer_lock_sync.sv
// Two-flop synchroniser for the asynchronous DCM/PLL LOCKED indications.
module lock_sync (
  input  logic clk,
  input  logic rst_,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pclk_mode_sequencer.sv
// Brings up / reconfigures dcmspi -> DCM_CLKGEN -> PLL and releases the pixel reset once clocks are stable.
// All control outputs are registered from the next state so dcm_go and the resets cannot glitch.
module pclk_mode_sequencer
  import pclk_mode_pkg::*;
#(
  parameter logic [1:0] DEFAULT_MODE = 2'd0,
  parameter int         RST_HOLD_CYC = 16,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter int         SETTLE_CYC   = 1024,
  parameter int         MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [1:0]  mode_sel,
  input  logic        dcm_busy,
  input  logic        dcm_progdone,
  input  logic        dcm_locked,
  input  logic        pll_locked,
  output logic        dcm_rst,
  output logic        dcm_go,
  output logic [7:0]  dcm_m,
  output logic [7:0]  dcm_d,
  output logic        pll_rst,
  output logic        video_rst,
  output logic [11:0] tc_hsblnk,
  output logic [11:0] tc_hssync,
  output logic [11:0] tc_hesync,
  output logic [11:0] tc_heblnk,
  output logic [11:0] tc_vsblnk,
  output logic [11:0] tc_vssync,
  output logic [11:0] tc_vesync,
  output logic [11:0] tc_veblnk,
  output logic        hvsync_polarity,
  output logic [1:0]  mode_active,
  output logic        ready,
  output logic        error,
  output logic [7:0]  lock_loss_cnt
);

  localparam logic [23:0] HOLD_LAST   = 24'(RST_HOLD_CYC - 1);
  localparam logic [23:0] TO_LAST     = 24'(TIMEOUT_CYC - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYC - 1);
  localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);
  localparam mode_cfg_t   CFG_RST     = mode_cfg(DEFAULT_MODE);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  mode_q;
  logic [1:0]  sel_prev_q;
  logic        arm_q, arm_d;
  mode_cfg_t   cfg_q;
  logic        go_q, dcm_rst_q, pll_rst_q, video_rst_q, ready_q, error_q;
  logic        dcm_lk, pll_lk, sel_valid, retry_fail, timeout;

  lock_sync u_dcm_sync (.clk(clk), .rst_(rst_), .async_i(dcm_locked), .sync_o(dcm_lk));
  lock_sync u_pll_sync (.clk(clk), .rst_(rst_), .async_i(pll_locked), .sync_o(pll_lk));

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    arm_d      = 1'b0;
    retry_fail = 1'b0;
    sel_valid  = (mode_sel != MODE_RSVD);
    pend_d     = sel_valid ? mode_sel : pend_q;
    timeout    = (cnt_q == TO_LAST);
    case (state_q)
      ST_HOLD:      if (cnt_q == HOLD_LAST) state_d = ST_PROG;
      ST_PROG:      state_d = ST_WAIT_DONE;
      // dcmspi needs a couple of cycles to raise BUSY after GO.
      ST_WAIT_DONE: if (cnt_q >= 24'd2 && !dcm_busy && dcm_progdone) state_d = ST_WAIT_DCM;
                    else if (timeout) retry_fail = 1'b1;
      ST_WAIT_DCM:  if (dcm_lk) state_d = ST_WAIT_PLL;
                    else if (timeout) retry_fail = 1'b1;
      ST_WAIT_PLL:  if (pll_lk) state_d = ST_SETTLE;
                    else if (timeout) retry_fail = 1'b1;
      ST_SETTLE:    if (!dcm_lk || !pll_lk) retry_fail = 1'b1;
                    else if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
      ST_RUN: begin
        retry_d = '0;
        if (!dcm_lk || !pll_lk) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = ST_HOLD;
        end else if (pend_d != mode_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_FAIL: begin
        // Re-requesting the failed mode must be a fresh write that holds for two cycles.
        arm_d = (mode_sel == mode_q) && (arm_q || mode_sel != sel_prev_q);
        if ((sel_valid && mode_sel != mode_q) || (arm_q && mode_sel == mode_q)) begin
          state_d = ST_HOLD;
          retry_d = '0;
        end
      end
      default:      state_d = ST_HOLD;
    endcase
    if (retry_fail) begin
      if (retry_q + 8'd1 >= RETRY_MAX) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_HOLD;
        retry_d = retry_q + 8'd1;
      end
    end
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pend_q      <= DEFAULT_MODE;
      mode_q      <= DEFAULT_MODE;
      sel_prev_q  <= DEFAULT_MODE;
      arm_q       <= 1'b0;
      cfg_q       <= CFG_RST;
      go_q        <= 1'b0;
      dcm_rst_q   <= 1'b1;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pend_q      <= pend_d;
      sel_prev_q  <= mode_sel;
      arm_q       <= arm_d;
      // Load on PROG entry so M/D are already valid while GO is high.
      if (state_d == ST_PROG) begin
        mode_q <= pend_q;
        cfg_q  <= mode_cfg(pend_q);
      end
      go_q        <= (state_d == ST_PROG);
      dcm_rst_q   <= (state_d inside {ST_HOLD, ST_FAIL});
      pll_rst_q   <= (state_d inside {ST_HOLD, ST_PROG, ST_WAIT_DONE, ST_WAIT_DCM, ST_FAIL});
      video_rst_q <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      error_q     <= (state_d == ST_FAIL);
    end
  end

  assign dcm_rst         = dcm_rst_q;
  assign dcm_go          = go_q;
  assign dcm_m           = cfg_q.m;
  assign dcm_d           = cfg_q.d;
  assign pll_rst         = pll_rst_q;
  assign video_rst       = video_rst_q;
  assign tc_hsblnk       = cfg_q.hsblnk;
  assign tc_hssync       = cfg_q.hssync;
  assign tc_hesync       = cfg_q.hesync;
  assign tc_heblnk       = cfg_q.heblnk;
  assign tc_vsblnk       = cfg_q.vsblnk;
  assign tc_vssync       = cfg_q.vssync;
  assign tc_vesync       = cfg_q.vesync;
  assign tc_veblnk       = cfg_q.veblnk;
  assign hvsync_polarity = cfg_q.pol;
  assign mode_active     = mode_q;
  assign ready           = ready_q;
  assign error           = error_q;
  assign lock_loss_cnt   = loss_q;

endmodule

// File: tb/tb_pclk_mode_sequencer.sv
// Directed bench for pclk_mode_sequencer with a small DCM/PLL behavioural model.
module tb_pclk_mode_sequencer;

  localparam int SETTLE = 1024;
  localparam int SEL_READY = 0, SEL_ERROR = 1, SEL_GO = 2, SEL_PLL = 3, SEL_PLLRST = 4, SEL_VRST = 5;

  logic        clk, rst_;
  logic [1:0]  mode_sel;
  logic        dcm_busy, dcm_progdone, dcm_locked, pll_locked;
  logic        dcm_rst, dcm_go, pll_rst, video_rst, hvsync_polarity, ready, error;
  logic [7:0]  dcm_m, dcm_d, lock_loss_cnt;
  logic [11:0] tc_hsblnk, tc_hssync, tc_hesync, tc_heblnk;
  logic [11:0] tc_vsblnk, tc_vssync, tc_vesync, tc_veblnk;
  logic [1:0]  mode_active;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;
  logic [7:0] m_go = '0, d_go = '0;
  logic dcm_en = 1'b1;
  int pll_glitch = 0;

  pclk_mode_sequencer #(.TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst_(rst_), .mode_sel(mode_sel),
    .dcm_busy(dcm_busy), .dcm_progdone(dcm_progdone),
    .dcm_locked(dcm_locked), .pll_locked(pll_locked),
    .dcm_rst(dcm_rst), .dcm_go(dcm_go), .dcm_m(dcm_m), .dcm_d(dcm_d),
    .pll_rst(pll_rst), .video_rst(video_rst),
    .tc_hsblnk(tc_hsblnk), .tc_hssync(tc_hssync), .tc_hesync(tc_hesync), .tc_heblnk(tc_heblnk),
    .tc_vsblnk(tc_vsblnk), .tc_vssync(tc_vssync), .tc_vesync(tc_vesync), .tc_veblnk(tc_veblnk),
    .hvsync_polarity(hvsync_polarity), .mode_active(mode_active),
    .ready(ready), .error(error), .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // DCM/PLL model: progdone 10 cycles after GO, DCM lock 100 later, PLL lock 50 after its reset drops.
  initial begin
    int done_cnt, dlk_cnt, plk_cnt;
    done_cnt = 0; dlk_cnt = 0; plk_cnt = 50;
    dcm_busy = 1'b0; dcm_progdone = 1'b0; dcm_locked = 1'b0; pll_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ || dcm_rst) begin
        dcm_busy = 1'b0; dcm_progdone = 1'b0; dcm_locked = 1'b0; done_cnt = 0; dlk_cnt = 0;
      end else if (dcm_go) begin
        dcm_busy = 1'b1; dcm_progdone = 1'b0; done_cnt = 10;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          dcm_busy = 1'b0; dcm_progdone = 1'b1;
          if (dcm_en) dlk_cnt = 100;
        end
      end else if (dlk_cnt > 0) begin
        dlk_cnt--;
        if (dlk_cnt == 0) dcm_locked = 1'b1;
      end
      if (!rst_ || pll_rst) begin
        pll_locked = 1'b0; plk_cnt = 50; pll_glitch = 0;
      end else if (plk_cnt > 0) begin
        plk_cnt--;
        if (plk_cnt == 0) pll_locked = 1'b1;
      end else if (pll_glitch > 0) begin
        pll_glitch--;
        pll_locked = (pll_glitch == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (dcm_go === 1'b1) begin
        go_cnt++; m_go = dcm_m; d_go = dcm_d;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input string tag, input int sel, input logic val, input int budget,
                            output int cyc);
    logic s;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      case (sel)
        SEL_READY:  s = ready;
        SEL_ERROR:  s = error;
        SEL_GO:     s = dcm_go;
        SEL_PLL:    s = pll_locked;
        SEL_PLLRST: s = pll_rst;
        default:    s = video_rst;
      endcase
      if (s === val || cyc >= budget) break;
    end
    tests++;
    assert (s === val) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b within %0d cycles", tag, s, val, budget);
    end
  endtask

  initial begin
    int cyc, g0;
    rst_ = 1'b0; mode_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_dcm_rst", dcm_rst, 1);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_video_rst", video_rst, 1);
    chk("rst_go", dcm_go, 0);
    chk("rst_ready", ready, 0);
    chk("rst_error", error, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    chk("rst_mode", mode_active, 0);
    chk("rst_m", dcm_m, 198);
    chk("rst_hsblnk", tc_hsblnk, 1919);

    // 1: bring-up in 1080p
    rst_ = 1'b1;
    wait_until("t1_pll_lock", SEL_PLL, 1'b1, 400, cyc);
    wait_until("t1_ready", SEL_READY, 1'b1, SETTLE + 50, cyc);
    tests++;
    assert (cyc >= SETTLE && cyc <= SETTLE + 5) else begin
      fails++;
      $error("FAIL t1_settle_delay: observed %0d expected %0d..%0d", cyc, SETTLE, SETTLE + 5);
    end
    chk("t1_go_cnt", go_cnt, 1);
    chk("t1_m", m_go, 198);
    chk("t1_d", d_go, 66);
    chk("t1_heblnk", tc_heblnk, 2199);
    chk("t1_veblnk", tc_veblnk, 1124);
    chk("t1_video_rst", video_rst, 0);
    chk("t1_pol", hvsync_polarity, 0);

    // 2: switch to 480p from RUN
    g0 = go_cnt;
    mode_sel = 2'd2;
    @(negedge clk);
    chk("t2_video_rst", video_rst, 1);
    chk("t2_ready_low", ready, 0);
    wait_until("t2_ready", SEL_READY, 1'b1, 2000, cyc);
    chk("t2_go_cnt", go_cnt, g0 + 1);
    chk("t2_m", m_go, 26);
    chk("t2_d", d_go, 49);
    chk("t2_pol", hvsync_polarity, 1);
    chk("t2_hsblnk", tc_hsblnk, 719);
    chk("t2_mode", mode_active, 2);

    // 4: PLL lock glitch while running
    g0 = go_cnt;
    pll_glitch = 6;
    wait_until("t4_video_rst", SEL_VRST, 1'b1, 10, cyc);
    chk("t4_loss", lock_loss_cnt, 1);
    chk("t4_ready_low", ready, 0);
    wait_until("t4_ready", SEL_READY, 1'b1, 2000, cyc);
    chk("t4_go_cnt", go_cnt, g0 + 1);
    chk("t4_m", m_go, 26);
    chk("t4_mode", mode_active, 2);

    // 5: request 1 then 3 while mode 0 is waiting for PLL lock
    g0 = go_cnt;
    mode_sel = 2'd0;
    @(negedge clk);
    wait_until("t5_pll_rst_low", SEL_PLLRST, 1'b0, 400, cyc);
    mode_sel = 2'd1;
    repeat (3) @(negedge clk);
    mode_sel = 2'd3;
    wait_until("t5_ready0", SEL_READY, 1'b1, SETTLE + 100, cyc);
    chk("t5_mode0", mode_active, 0);
    @(negedge clk);
    chk("t5_run_one_cycle", ready, 0);
    chk("t5_video_rst", video_rst, 1);
    wait_until("t5_ready1", SEL_READY, 1'b1, 2000, cyc);
    chk("t5_mode1", mode_active, 1);
    chk("t5_go_cnt", go_cnt, g0 + 2);
    chk("t5_m", m_go, 198);
    chk("t5_d", d_go, 133);
    chk("t5_hsblnk", tc_hsblnk, 1279);

    // 3: DCM never locks -> three attempts then FAIL, recovered by a new mode
    g0 = go_cnt;
    dcm_en = 1'b0;
    mode_sel = 2'd0;
    wait_until("t3_error", SEL_ERROR, 1'b1, 5000, cyc);
    chk("t3_go_cnt", go_cnt, g0 + 3);
    chk("t3_ready", ready, 0);
    chk("t3_video_rst", video_rst, 1);
    chk("t3_dcm_rst", dcm_rst, 1);
    chk("t3_pll_rst", pll_rst, 1);
    dcm_en = 1'b1;
    mode_sel = 2'd1;
    @(negedge clk);
    chk("t3_error_clr", error, 0);
    wait_until("t3_ready", SEL_READY, 1'b1, 2000, cyc);
    chk("t3_mode", mode_active, 1);
    chk("t3_go_cnt2", go_cnt, g0 + 4);

    // 6: asynchronous reset during WAIT_DONE
    mode_sel = 2'd2;
    wait_until("t6_go", SEL_GO, 1'b1, 100, cyc);
    repeat (3) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    chk("t6_dcm_rst", dcm_rst, 1);
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_video_rst", video_rst, 1);
    chk("t6_go", dcm_go, 0);
    chk("t6_mode", mode_active, 0);
    chk("t6_m", dcm_m, 198);
    chk("t6_loss", lock_loss_cnt, 0);
    g0 = go_cnt;
    repeat (3) @(negedge clk);
    chk("t6_no_go_in_reset", go_cnt, g0);
    rst_ = 1'b1;
    wait_until("t6_ready", SEL_READY, 1'b1, 2000, cyc);
    chk("t6_mode_after", mode_active, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pclk_mode_sequencer.md
Name: pclk_mode_sequencer

Overview:
- Control FSM that brings up and reconfigures the HDMI TX pixel-clock chain: dcmspi → DCM_CLKGEN → PLL_BASE/BUFPLL → timing/encoder reset.
- Selects one of three video modes, programs DCM M/D through the dcmspi GO/BUSY/PROGDONE handshake, and waits for DCM then PLL lock.
- Drives the matching tc_* timing constants and sync polarity.
- Releases the pixel-domain reset only after the clock chain is stable.
- Sits in top, clocked by clk50m_bufg.

Parameters:
DEFAULT_MODE, 2'd0, mode used after reset (0=1080p60, 1=720p60, 2=480p60)
RST_HOLD_CYC, 16, cycles dcm_rst/pll_rst held before programming
TIMEOUT_CYC, 1000000, max wait per lock/done phase (20 ms at 50 MHz)
SETTLE_CYC, 1024, cycles after PLL lock before video_rst release
MAX_RETRY, 3, reprogram attempts before FAIL

Ports:
clk  in  1  50 MHz control clock (clk50m_bufg)
rst_  in  1  asynchronous active-low reset
mode_sel  in  2  requested mode; 2'd3 reserved, ignored
dcm_busy  in  1  dcmspi BUSY
dcm_progdone  in  1  DCM PROGDONE
dcm_locked  in  1  DCM LOCKED (async, 2-flop synchronised inside)
pll_locked  in  1  PLL LOCKED (async, 2-flop synchronised inside)
dcm_rst  out  1  dcmspi RST, active-high
dcm_go  out  1  one-cycle GO pulse
dcm_m  out  8  M-1
dcm_d  out  8  D-1
pll_rst  out  1  PLL_BASE RST, active-high
video_rst  out  1  pixel-domain reset request, active-high (consumer resynchronises it to pclk)
tc_hsblnk, tc_hssync, tc_hesync, tc_heblnk  out  12 each  horizontal timing constants
tc_vsblnk, tc_vssync, tc_vesync, tc_veblnk  out  12 each  vertical timing constants
hvsync_polarity  out  1  1 = sync inverted
mode_active  out  2  mode currently programmed
ready  out  1  clocks locked, video running
error  out  1  retries exhausted
lock_loss_cnt  out  8  saturating count of lock drops while in RUN

Behaviour:
Reset values:
- dcm_rst=1, pll_rst=1, video_rst=1, dcm_go=0, ready=0, error=0, lock_loss_cnt=0.
- mode_active=DEFAULT_MODE; tc_*/polarity/dcm_m/dcm_d hold DEFAULT_MODE values.
- State = HOLD.

Mode table (M/D shown before the −1 applied on dcm_m/dcm_d):
- 0 (1080p, 148.5 MHz): M=199, D=67; h 1919/2007/2051/2199; v 1079/1083/1088/1124; pol 0.
- 1 (720p, 74.25 MHz): M=199, D=134; h 1279/1389/1429/1649; v 719/724/729/749; pol 0.
- 2 (480p, 27 MHz): M=27, D=50; h 719/735/797/857; v 479/488/494/524; pol 1.

FSM states:
- HOLD: dcm_rst=pll_rst=video_rst=1 for RST_HOLD_CYC cycles, then PROG.
- PROG: dcm_rst=0; all outputs load from target mode; dcm_go=1 for exactly one cycle; go to WAIT_DONE.
- WAIT_DONE: ignore the first 2 cycles. Exit to WAIT_DCM when dcm_busy==0 && dcm_progdone==1.
- WAIT_DCM: exit to WAIT_PLL when synced dcm_locked==1. pll_rst drops on that same transition.
- WAIT_PLL: exit to SETTLE when synced pll_locked==1.
- SETTLE: if either lock drops, go to HOLD (counts as a retry). Otherwise, after SETTLE_CYC cycles, enter RUN.
- RUN: video_rst=0, ready=1.
  - Valid mode_sel ≠ mode_active: go to HOLD with the new target; retry counter cleared.
  - Either synced lock low: lock_loss_cnt += 1 (saturates at 255); go to HOLD, same mode.
- FAIL: error=1; all resets asserted. Leave only on a valid mode_sel change, or any mode_sel write equal to the failed mode that persists 2 cycles; go to HOLD.

Timeouts:
- One shared 24-bit counter, cleared on every state entry.
- TIMEOUT_CYC elapsed in WAIT_DONE/WAIT_DCM/WAIT_PLL: retry += 1 → HOLD. If retry == MAX_RETRY → FAIL.

Mode-change rules:
- mode_sel is sampled every cycle.
- Changes during HOLD..SETTLE are latched as pending. After reaching RUN, a pending mode ≠ active restarts immediately (RUN held for one cycle).
- mode_sel=3 is never latched.

Ordering rules:
- tc_* and polarity change only in PROG, while video_rst=1.
- video_rst rises in the same cycle as leaving RUN, before any clock disturbance.

Decomposition:
- Package pclk_mode_pkg: mode encoding constants, state enum, per-mode M/D and 8 timing constants as a function mode→record.
- Sub-module lock_sync: 2-flop synchroniser, reused twice.

Test Plan:
1. Reset, mode_sel=0; BFM raises progdone 10 cycles after go, dcm_locked +100 cycles, pll_locked +50 cycles → exactly one go pulse with dcm_m=198, dcm_d=66; ready rises SETTLE_CYC cycles after pll lock; tc_heblnk=2199, tc_veblnk=1124.
2. In RUN, mode_sel=2 → video_rst=1 next cycle; dcm_m=26, dcm_d=49, polarity=1, tc_hsblnk=719; ready returns after relock with mode_active=2.
3. dcm_locked never rises (TIMEOUT_CYC=1000) → 3 go pulses, then error=1, ready=0; then mode_sel=1 → sequence restarts and completes.
4. In RUN, pll_locked pulses low 5 cycles → lock_loss_cnt=1, video_rst reasserted, full reprogram of same mode.
5. mode_sel toggled 1 then 3 during WAIT_PLL → mode 0 completes, RUN held one cycle, then reprograms to mode 1; mode 3 never applied.
6. rst_ asserted mid WAIT_DONE → all outputs at reset values asynchronously; dcm_go never glitches.
